// File: rtl/pixel_line_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_line_fifo
//  Purpose  : Single-clock pixel FIFO between the camera pixel assembler and
//             the SDRAM/display consumer, with full/empty and live occupancy.
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_line_fifo #(
   parameter int DATA_WIDTH       = 16,
   parameter int FIFO_DEPTH_WIDTH = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        write,
   input  logic                        read,
   input  logic [DATA_WIDTH-1:0]       data_write,
   output logic [DATA_WIDTH-1:0]       data_read,
   output logic                        full,
   output logic                        empty,
   output logic [FIFO_DEPTH_WIDTH-1:0] data_count_r
);

   localparam int                          c_depth     = 1 << FIFO_DEPTH_WIDTH;
   localparam logic [FIFO_DEPTH_WIDTH-1:0] c_count_max = '1;

   logic [DATA_WIDTH-1:0]       r_mem [0:c_depth-1];
   logic [FIFO_DEPTH_WIDTH-1:0] r_wptr;
   logic [FIFO_DEPTH_WIDTH-1:0] r_rptr;
   logic [FIFO_DEPTH_WIDTH-1:0] r_count;
   logic [DATA_WIDTH-1:0]       r_data_read;

   logic w_full;
   logic w_empty;
   logic w_wr_ok;
   logic w_rd_ok;

   // One slot is sacrificed so the count fits the pointer width exactly.
   assign w_full  = (r_count == c_count_max);
   assign w_empty = (r_count == '0);
   assign w_wr_ok = write & ~w_full;
   assign w_rd_ok = read & ~w_empty;

   // Storage is left uncleared by reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wptr] <= data_write;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_data_read <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd_ok) begin
            r_rptr      <= r_rptr + 1'b1;
            r_data_read <= r_mem[r_rptr];
         end
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign data_read    = r_data_read;
   assign full         = w_full;
   assign empty        = w_empty;
   assign data_count_r = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_line_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_line_fifo
//  Purpose  : Scoreboard bench for pixel_line_fifo at default parameters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_line_fifo;

   localparam int c_cap = 1023;

   logic        clk;
   logic        rst;
   logic        write;
   logic        read;
   logic [15:0] data_write;
   logic [15:0] data_read;
   logic        full;
   logic        empty;
   logic [9:0]  data_count_r;

   int          n_tests;
   int          n_fail;
   logic [15:0] sb[$];
   logic [15:0] m_last;

   pixel_line_fifo #(
      .DATA_WIDTH      (16),
      .FIFO_DEPTH_WIDTH(10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .write       (write),
      .read        (read),
      .data_write  (data_write),
      .data_read   (data_read),
      .full        (full),
      .empty       (empty),
      .data_count_r(data_count_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle and advance the reference model; outputs settle by return.
   task automatic step(input logic w, input logic r, input logic [15:0] d, output logic rd_acc);
      logic wo;
      logic ro;
      wo = w && (sb.size() < c_cap);
      ro = r && (sb.size() > 0);
      write      = w;
      read       = r;
      data_write = d;
      @(posedge clk);
      #1;
      write = 1'b0;
      read  = 1'b0;
      if (ro) m_last = sb.pop_front();
      if (wo) sb.push_back(d);
      rd_acc = ro;
   endtask

   task automatic test_reset();
      logic acc;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (empty !== 1'b1 || full !== 1'b0 || data_count_r !== 10'd0 || data_read !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_init: empty=%b full=%b count=%0d data=%h, need 1 0 0 0000",
                  empty, full, data_count_r, data_read);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i), acc);
      step(1'b0, 1'b1, 16'h0, acc);
      n_tests++;
      if (data_count_r !== 10'd4 || data_read !== 16'h0100) begin
         n_fail++;
         $display("FAIL reset_prefill: count=%0d data=%h, need 4 0100", data_count_r, data_read);
      end
      step(1'b1, 1'b0, 16'h0105, acc);
      rst = 1'b1;
      #1;
      n_tests++;
      if (empty !== 1'b1 || full !== 1'b0 || data_count_r !== 10'd0 || data_read !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_async: empty=%b full=%b count=%0d data=%h, need 1 0 0 0000",
                  empty, full, data_count_r, data_read);
      end
      sb.delete();
      m_last = 16'h0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 16'hAAAA, acc);
      step(1'b0, 1'b1, 16'h0, acc);
      n_tests++;
      if (data_read !== 16'hAAAA || acc !== 1'b1 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_after: data=%h empty=%b, need aaaa 1", data_read, empty);
      end
   endtask

   task automatic test_basic_order();
      logic        acc;
      logic [15:0] exp_v [3];
      exp_v[0] = 16'h1111;
      exp_v[1] = 16'h2222;
      exp_v[2] = 16'h3333;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, exp_v[i], acc);
      n_tests++;
      if (data_count_r !== 10'd3 || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL order_count: count=%0d empty=%b, need 3 0", data_count_r, empty);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 16'h0, acc);
         n_tests++;
         if (data_read !== exp_v[i] || data_count_r !== 10'(2 - i)) begin
            n_fail++;
            $display("FAIL order_data%0d: data=%h count=%0d, need %h %0d",
                     i, data_read, data_count_r, exp_v[i], 2 - i);
         end
      end
      n_tests++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL order_empty: empty=%b, need 1", empty);
      end
   endtask

   task automatic test_fill();
      logic acc;
      int   bad;
      for (int i = 0; i < c_cap; i++) step(1'b1, 1'b0, 16'(i), acc);
      n_tests++;
      if (full !== 1'b1 || data_count_r !== 10'd1023 || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_full: full=%b count=%0d, need 1 1023", full, data_count_r);
      end
      step(1'b1, 1'b0, 16'hFFFF, acc);
      n_tests++;
      if (full !== 1'b1 || data_count_r !== 10'd1023) begin
         n_fail++;
         $display("FAIL fill_overflow: full=%b count=%0d, need 1 1023", full, data_count_r);
      end
      bad = 0;
      for (int i = 0; i < c_cap; i++) begin
         step(1'b0, 1'b1, 16'h0, acc);
         if (data_read !== 16'(i) && bad < 4) begin
            bad++;
            $display("FAIL fill_drain: entry %0d data=%h, need %h", i, data_read, 16'(i));
         end
      end
      n_tests++;
      if (bad != 0) n_fail++;
      n_tests++;
      if (empty !== 1'b1 || full !== 1'b0 || data_count_r !== 10'd0) begin
         n_fail++;
         $display("FAIL fill_empty: empty=%b full=%b count=%0d, need 1 0 0", empty, full, data_count_r);
      end
   endtask

   task automatic test_underflow();
      logic acc;
      step(1'b1, 1'b0, 16'h0042, acc);
      step(1'b0, 1'b1, 16'h0, acc);
      step(1'b0, 1'b1, 16'h0, acc);
      step(1'b0, 1'b1, 16'h0, acc);
      n_tests++;
      if (data_read !== 16'h0042 || data_count_r !== 10'd0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL underflow_hold: data=%h count=%0d, need 0042 0", data_read, data_count_r);
      end
      step(1'b1, 1'b0, 16'h0007, acc);
      step(1'b0, 1'b1, 16'h0, acc);
      n_tests++;
      if (data_read !== 16'h0007 || data_count_r !== 10'd0) begin
         n_fail++;
         $display("FAIL underflow_recover: data=%h count=%0d, need 0007 0", data_read, data_count_r);
      end
   endtask

   task automatic test_simultaneous();
      logic acc;
      for (int i = 0; i < 500; i++) step(1'b1, 1'b0, 16'h5000 + 16'(i), acc);
      step(1'b1, 1'b1, 16'h6000, acc);
      n_tests++;
      if (data_count_r !== 10'd500 || data_read !== 16'h5000) begin
         n_fail++;
         $display("FAIL simul_mid: count=%0d data=%h, need 500 5000", data_count_r, data_read);
      end
      while (sb.size() < c_cap) step(1'b1, 1'b0, 16'h7000 + 16'(sb.size()), acc);
      step(1'b1, 1'b1, 16'hDEAD, acc);
      n_tests++;
      if (data_count_r !== 10'd1022 || full !== 1'b0 || data_read !== 16'h5001) begin
         n_fail++;
         $display("FAIL simul_full: count=%0d full=%b data=%h, need 1022 0 5001",
                  data_count_r, full, data_read);
      end
      while (sb.size() > 0) begin
         step(1'b0, 1'b1, 16'h0, acc);
         if (data_read !== m_last) begin
            n_tests++;
            n_fail++;
            $display("FAIL simul_drain: data=%h, need %h", data_read, m_last);
         end
      end
      n_tests++;
      if (data_read === 16'hDEAD) begin
         n_fail++;
         $display("FAIL simul_dropped: data=dead, need dropped word absent");
      end
      m_last = data_read;
      step(1'b1, 1'b1, 16'h0BEE, acc);
      n_tests++;
      if (data_count_r !== 10'd1 || data_read !== m_last || acc !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_empty: count=%0d data=%h, need 1 %h", data_count_r, data_read, m_last);
      end
      step(1'b0, 1'b1, 16'h0, acc);
      n_tests++;
      if (data_read !== 16'h0BEE || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_empty_read: data=%h empty=%b, need 0bee 1", data_read, empty);
      end
   endtask

   task automatic test_wrap();
      logic acc;
      logic w;
      logic r;
      int   sent;
      int   recv;
      int   cycles;
      int   bad;
      sent   = 0;
      recv   = 0;
      cycles = 0;
      bad    = 0;
      step(1'b1, 1'b0, 16'h4000, acc);
      sent = 1;
      while ((sent < 3000 || sb.size() > 0) && cycles < 20000) begin
         w = (sent < 3000) && (sb.size() < 900) && ($urandom_range(0, 99) < 55);
         r = ((sb.size() > 1) || (sent >= 3000)) && ($urandom_range(0, 99) < 50);
         step(w, r, 16'h4000 + 16'(sent), acc);
         if (w) sent++;
         if (acc) begin
            if (data_read !== 16'h4000 + 16'(recv) && bad < 4) begin
               bad++;
               $display("FAIL wrap_data: word %0d data=%h, need %h", recv, data_read, 16'h4000 + 16'(recv));
            end
            recv++;
         end
         if ((empty !== (sb.size() == 0)) || (full !== 1'b0) ||
             (data_count_r !== 10'(sb.size())) ) begin
            if (bad < 4) $display("FAIL wrap_flags: empty=%b full=%b count=%0d, need %b 0 %0d",
                                  empty, full, data_count_r, sb.size() == 0, sb.size());
            bad++;
         end
         cycles++;
      end
      n_tests++;
      if (bad != 0) n_fail++;
      n_tests++;
      if (recv != 3000 || cycles >= 20000) begin
         n_fail++;
         $display("FAIL wrap_count: received %0d in %0d cycles, need 3000", recv, cycles);
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      m_last     = 16'h0;
      rst        = 1'b1;
      write      = 1'b0;
      read       = 1'b0;
      data_write = 16'h0;
      test_reset();
      test_basic_order();
      test_fill();
      test_underflow();
      test_simultaneous();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
